// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C passthrough receive path: FSM state
// encodings and the word-termination cause codes reported to the controller.
package i2c_passthru_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SCL0      = 4'd1,
    ST_SCL0_REL  = 4'd2,
    ST_SCL1      = 4'd3,
    ST_DONE      = 4'd4,
    ST_VIOLATION = 4'd5
  } state_t;

  localparam logic [1:0] COND_WORD  = 2'd0;
  localparam logic [1:0] COND_START = 2'd1;
  localparam logic [1:0] COND_STOP  = 2'd2;

endpackage

// File: rtl/i2c_passthru_ref_timer.sv
// Down-counter timed by reference ticks. Loads LOAD while i_rst_load is
// high, otherwise decrements once per tick and parks at zero; o_tc flags zero.
module i2c_passthru_ref_timer #(
  parameter int WIDTH = 6,
  parameter int LOAD  = 38
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_rst_load,
  input  logic i_pulse_ref,
  output logic o_tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: reload has priority over a tick; never wraps below zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (i_rst_load) begin
      cnt_d = WIDTH'(LOAD);
    end else if (i_pulse_ref && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register, synchronously reset to the load value.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (!i_rstn) begin
      cnt_q <= WIDTH'(LOAD);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == '0);

endmodule

// File: rtl/i2c_passthru_wordrx.sv
// Multi-bit receive engine for the I2C passthrough. Clocks up to NUM_BITS
// SCL cycles on the driven side, shifts sampled SDA into a word, classifies
// mid-bit SDA edges (START/STOP in master mode, violation in slave mode) and
// then holds SCL low until the transmit side reports completion.
// Optional clock-stretch timeout: define I2C_PASSTHRU_WORDRX_STRETCH_TO_EN.
module i2c_passthru_wordrx
  import i2c_passthru_pkg::*;
#(
  parameter int NUM_BITS        = 8,
  parameter int WIDTH_BIT_CNT   = 5,
  parameter int F_REF_T_LOW     = 38,
  parameter int F_REF_T_HIGH    = 30,
  parameter int WIDTH_F_REF     = 6,
  parameter int F_REF_T_TIMEOUT = 255,
  parameter int WIDTH_F_REF_TO  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_f_ref,
  input  logic                     i_start_rx,
  input  logic                     i_rx_frm_slv,
  input  logic                     i_tx_done,
  input  logic                     i_scl,
  input  logic                     i_sda,
  output logic                     o_scl,
  output logic                     o_sda,
  output logic [NUM_BITS-1:0]      o_data,
  output logic [WIDTH_BIT_CNT-1:0] o_bit_cnt,
  output logic [1:0]               o_cond,
  output logic                     o_rx_done,
  output logic                     o_violation,
  output logic                     o_timeout
);

  // Reject configurations whose counters cannot represent their load values.
  if (NUM_BITS < 1 || NUM_BITS > 16 || NUM_BITS >= (1 << WIDTH_BIT_CNT) ||
      F_REF_T_LOW < 2 || F_REF_T_HIGH < 2 ||
      F_REF_T_LOW >= (1 << WIDTH_F_REF) || F_REF_T_HIGH >= (1 << WIDTH_F_REF) ||
      F_REF_T_TIMEOUT < 1 || F_REF_T_TIMEOUT >= (1 << WIDTH_F_REF_TO)) begin : g_bad_cfg
    $error("i2c_passthru_wordrx: unsupported parameter set");
  end

  state_t                   state_q, state_d;
  logic                     slv_q, slv_d;
  logic                     sda_init_q, sda_init_d;
  logic [NUM_BITS-1:0]      data_q, data_d;
  logic [WIDTH_BIT_CNT-1:0] cnt_q, cnt_d;
  logic [1:0]               cond_q, cond_d;
  logic                     f_ref_q;
  logic                     pulse_ref;
  logic                     low_load, low_tc;
  logic                     high_load, high_tc;
  logic                     bit_end;

`ifdef I2C_PASSTHRU_WORDRX_STRETCH_TO_EN
  logic to_tc;
  logic timeout_q, timeout_d;
`endif

  assign pulse_ref = i_f_ref & ~f_ref_q;
  assign o_sda     = 1'b1;
  assign o_data    = data_q;
  assign o_bit_cnt = cnt_q;
  assign o_cond    = cond_q;

  i2c_passthru_ref_timer #(.WIDTH(WIDTH_F_REF), .LOAD(F_REF_T_LOW)) u_low_timer (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_rst_load (low_load),
    .i_pulse_ref(pulse_ref),
    .o_tc       (low_tc)
  );

  i2c_passthru_ref_timer #(.WIDTH(WIDTH_F_REF), .LOAD(F_REF_T_HIGH)) u_high_timer (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_rst_load (high_load),
    .i_pulse_ref(pulse_ref),
    .o_tc       (high_tc)
  );

`ifdef I2C_PASSTHRU_WORDRX_STRETCH_TO_EN
  // Stretch timeout only runs while waiting for SCL to rise after release.
  i2c_passthru_ref_timer #(.WIDTH(WIDTH_F_REF_TO), .LOAD(F_REF_T_TIMEOUT)) u_to_timer (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_rst_load (state_q != ST_SCL0_REL),
    .i_pulse_ref(pulse_ref),
    .o_tc       (to_tc)
  );

  // One-cycle timeout pulse, raised together with the move to ST_VIOLATION.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Next-state, datapath updates and Moore outputs of the receive FSM.
  always_comb begin
    state_d     = state_q;
    slv_d       = slv_q;
    sda_init_d  = sda_init_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    cond_d      = cond_q;
    low_load    = 1'b0;
    high_load   = 1'b0;
    bit_end     = 1'b0;
    o_scl       = 1'b1;
    o_rx_done   = 1'b0;
    o_violation = 1'b0;
`ifdef I2C_PASSTHRU_WORDRX_STRETCH_TO_EN
    timeout_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        o_rx_done = 1'b1;
        slv_d     = i_rx_frm_slv;
        low_load  = 1'b1;
        if (i_start_rx) begin
          data_d  = '0;
          cnt_d   = '0;
          cond_d  = COND_WORD;
          state_d = ST_SCL0;
        end
      end
      ST_SCL0: begin
        o_scl      = 1'b0;
        sda_init_d = i_sda;
        if (low_tc) state_d = ST_SCL0_REL;
      end
      ST_SCL0_REL: begin
        sda_init_d = i_sda;
        high_load  = 1'b1;
        if (i_scl) begin
          state_d = ST_SCL1;
        end
`ifdef I2C_PASSTHRU_WORDRX_STRETCH_TO_EN
        else if (to_tc) begin
          timeout_d = 1'b1;
          state_d   = ST_VIOLATION;
        end
`endif
      end
      ST_SCL1: begin
        if (slv_q) begin
          // We own SCL: any SCL drop or SDA edge during high is illegal.
          if (!i_scl || (i_sda != sda_init_q)) state_d = ST_VIOLATION;
          else if (high_tc)                    bit_end = 1'b1;
        end else begin
          // SCL fall wins over a simultaneous SDA change.
          if (!i_scl) begin
            bit_end = 1'b1;
          end else if (i_sda != sda_init_q) begin
            cond_d  = i_sda ? COND_STOP : COND_START;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        o_scl     = 1'b0;
        o_rx_done = 1'b1;
        if (i_tx_done) state_d = ST_IDLE;
      end
      ST_VIOLATION: begin
        o_violation = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bit_end) begin
      data_d   = NUM_BITS'({data_q, sda_init_q});
      cnt_d    = cnt_q + WIDTH_BIT_CNT'(1);
      low_load = 1'b1;
      if (cnt_d == WIDTH_BIT_CNT'(NUM_BITS)) begin
        cond_d  = COND_WORD;
        state_d = ST_DONE;
      end else begin
        state_d = ST_SCL0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      slv_q      <= 1'b0;
      sda_init_q <= 1'b1;
      data_q     <= '0;
      cnt_q      <= '0;
      cond_q     <= COND_WORD;
      f_ref_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slv_q      <= slv_d;
      sda_init_q <= sda_init_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      cond_q     <= cond_d;
      f_ref_q    <= i_f_ref;
    end
  end

endmodule

// File: tb/tb_i2c_passthru_wordrx.sv
// Self-checking bench for i2c_passthru_wordrx: directed table of receive
// transactions, hand-written corner sequences, and randomized transactions
// checked against an arithmetic model of the received word.
module tb_i2c_passthru_wordrx;

  localparam int NUM_BITS = 8;
  localparam int T_LOW    = 38;
  localparam int T_HIGH   = 30;
  localparam int T_TO     = 10;

  logic       clk = 1'b0, rstn = 1'b0, f_ref = 1'b0;
  logic       start_rx = 1'b0, rx_frm_slv = 1'b0, tx_done = 1'b0;
  logic       ext_scl = 1'b1, ext_sda = 1'b1;
  logic       scl_bus, sda_bus;
  logic       o_scl, o_sda, o_rx_done, o_violation, o_timeout;
  logic [7:0] o_data;
  logic [4:0] o_bit_cnt;
  logic [1:0] o_cond;

  int n_cmp = 0;
  int n_err = 0;

  assign scl_bus = o_scl & ext_scl;
  assign sda_bus = o_sda & ext_sda;

  i2c_passthru_wordrx #(
    .NUM_BITS(NUM_BITS), .WIDTH_BIT_CNT(5), .F_REF_T_LOW(T_LOW), .F_REF_T_HIGH(T_HIGH),
    .WIDTH_F_REF(6), .F_REF_T_TIMEOUT(T_TO), .WIDTH_F_REF_TO(8)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_f_ref(f_ref), .i_start_rx(start_rx),
    .i_rx_frm_slv(rx_frm_slv), .i_tx_done(tx_done), .i_scl(scl_bus), .i_sda(sda_bus),
    .o_scl(o_scl), .o_sda(o_sda), .o_data(o_data), .o_bit_cnt(o_bit_cnt),
    .o_cond(o_cond), .o_rx_done(o_rx_done), .o_violation(o_violation), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // Reference toggles every cycle: one tick on every other rising clock edge.
  initial forever begin
    @(posedge clk);
    #1 f_ref = ~f_ref;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // SCL phase monitor: ticks seen at edges while SCL is low / high
  // (first edge of each high phase is the release edge and is skipped).
  logic mon_en = 1'b0, mon_phase = 1'b0, mon_first = 1'b0, last_f = 1'b0, tick_n;
  int   lo_cnt = 0, hi_cnt = 0;
  int   lo_q[$], hi_q[$];

  always @(negedge clk) begin
    #1;
    tick_n = f_ref & ~last_f;
    last_f = f_ref;
    if (mon_en) begin
      if (o_scl != mon_phase) begin
        if (mon_phase) hi_q.push_back(hi_cnt);
        else           lo_q.push_back(lo_cnt);
        mon_phase = o_scl;
        lo_cnt    = 0;
        hi_cnt    = 0;
        mon_first = 1'b1;
      end
      if (!o_scl)         lo_cnt += int'(tick_n);
      else if (mon_first) mon_first = 1'b0;
      else                hi_cnt += int'(tick_n);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_scl(input logic lvl, input string name);
    int n = 0;
    while (o_scl !== lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, o_scl}, {31'd0, lvl});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (o_rx_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, o_rx_done}, 32'd1);
  endtask

  task automatic do_start(input logic slv);
    rx_frm_slv = slv;
    start_rx   = 1'b1;
    @(negedge clk);
    start_rx   = 1'b0;
  endtask

  // External master drives bits while SCL is low; flip_mode: 0 never,
  // 1 always, 2 random SDA change on the same cycle as SCL fall.
  task automatic master_txn(input int nb, input logic [7:0] val, input int term,
                            input int flip_mode, input bit rnd);
    logic b, v;
    bit   flip;
    ext_scl = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < nb; i++) begin
      b       = val[nb-1-i];
      ext_sda = b;
      wait_scl(1'b1, "m_rel");
      repeat (rnd ? $urandom_range(0, 3) : 1) @(negedge clk);
      ext_scl = 1'b1;
      if (rnd) start_rx = 1'b1;
      repeat (rnd ? $urandom_range(2, 6) : 3) @(negedge clk);
      flip     = (flip_mode == 1) || (flip_mode == 2 && $urandom_range(0, 1) == 1);
      start_rx = 1'b0;
      ext_scl  = 1'b0;
      if (flip) ext_sda = ~b;
      @(negedge clk);
    end
    if (term != 0) begin
      v       = (term == 1);
      ext_sda = v;
      wait_scl(1'b1, "m_term_rel");
      ext_scl = 1'b1;
      repeat (3) @(negedge clk);
      ext_sda = ~v;
      @(negedge clk);
    end
    wait_done("m_done");
  endtask

  // Slave presents SDA while SCL is low; DUT drives SCL. viol_bit >= 0
  // flips SDA mid-high on that bit and returns.
  task automatic slave_txn(input logic [7:0] val, input int viol_bit, input bit mon);
    ext_scl = 1'b1;
    lo_q.delete();
    hi_q.delete();
    do_start(1'b1);
    if (mon) begin
      mon_phase = 1'b0;
      lo_cnt    = 0;
      hi_cnt    = 0;
      mon_en    = 1'b1;
    end
    for (int i = 0; i < NUM_BITS; i++) begin
      ext_sda = val[NUM_BITS-1-i];
      wait_scl(1'b1, "s_high");
      if (i == viol_bit) begin
        repeat (5) @(negedge clk);
        ext_sda = ~ext_sda;
        @(negedge clk);
        return;
      end
      wait_scl(1'b0, "s_low");
    end
    wait_done("s_done");
    @(negedge clk);
    mon_en = 1'b0;
    if (mon) begin
      check("s_lo_phases", lo_q.size(), NUM_BITS);
      check("s_hi_phases", hi_q.size(), NUM_BITS);
      foreach (lo_q[k]) check("s_lo_ticks_min", {31'd0, lo_q[k] >= T_LOW}, 32'd1);
      foreach (hi_q[k]) check("s_hi_ticks", hi_q[k], T_HIGH);
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] ed, input int ec, input int econd);
    check({name, "_data"}, o_data, ed);
    check({name, "_cnt"}, o_bit_cnt, ec);
    check({name, "_cond"}, o_cond, econd);
    check({name, "_scl_held"}, {31'd0, o_scl}, 32'd0);
    check({name, "_sda"}, {31'd0, o_sda}, 32'd1);
    check({name, "_noviol"}, {31'd0, o_violation}, 32'd0);
  endtask

  task automatic finish_txn(input string name);
    ext_scl = 1'b1;
    ext_sda = 1'b1;
    repeat (3) @(negedge clk);
    check({name, "_done_hold"}, {30'd0, o_scl, o_rx_done}, 32'b01);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check({name, "_idle"}, {30'd0, o_scl, o_rx_done}, 32'b11);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    start_rx = 1'b0;
    tx_done  = 1'b0;
    ext_scl  = 1'b1;
    ext_sda  = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic       slv;
    int         nb;
    logic [7:0] val;
    int         term;
    logic [7:0] exp_data;
    int         exp_cnt;
    int         exp_cond;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses;
    vecs[0] = '{"m_a5",     1'b0, 8, 8'hA5, 0, 8'hA5, 8, 0};
    vecs[1] = '{"s_3c",     1'b1, 8, 8'h3C, 0, 8'h3C, 8, 0};
    vecs[2] = '{"m_start3", 1'b0, 3, 8'h05, 1, 8'h05, 3, 1};
    vecs[3] = '{"m_stop3",  1'b0, 3, 8'h05, 2, 8'h05, 3, 2};
    vecs[4] = '{"m_start0", 1'b0, 0, 8'h00, 1, 8'h00, 0, 1};
    vecs[5] = '{"s_ff",     1'b1, 8, 8'hFF, 0, 8'hFF, 8, 0};
    vecs[6] = '{"m_81",     1'b0, 8, 8'h81, 0, 8'h81, 8, 0};
    vecs[7] = '{"m_stop7",  1'b0, 7, 8'h55, 2, 8'h55, 7, 2};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_outs", {o_scl, o_sda, o_rx_done, o_violation, o_timeout}, 32'b11100);
    check("rst_data", o_data, 0);
    check("rst_cnt", o_bit_cnt, 0);
    check("rst_cond", o_cond, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].slv) slave_txn(vecs[i].val, -1, 1'b1);
      else             master_txn(vecs[i].nb, vecs[i].val, vecs[i].term, 0, 1'b0);
      check_result(vecs[i].name, vecs[i].exp_data, vecs[i].exp_cnt, vecs[i].exp_cond);
      finish_txn(vecs[i].name);
    end

    // SCL fall with simultaneous SDA change on every bit counts as data.
    master_txn(8, 8'hC3, 0, 1, 1'b0);
    check_result("m_flip", 8'hC3, 8, 0);
    ext_scl  = 1'b1;
    ext_sda  = 1'b1;
    tx_done  = 1'b1;
    start_rx = 1'b1;
    @(negedge clk);
    tx_done  = 1'b0;
    start_rx = 1'b0;
    check("done_start_same_cycle", {30'd0, o_scl, o_rx_done}, 32'b11);
    @(negedge clk);
    check("idle_no_start", {30'd0, o_scl, o_rx_done}, 32'b11);

    // Slave violation on the fourth bit: sticky until reset.
    slave_txn(8'hE7, 3, 1'b0);
    check("viol_next_cycle", {31'd0, o_violation}, 32'd1);
    start_rx = 1'b1;
    tx_done  = 1'b1;
    repeat (20) @(negedge clk);
    start_rx = 1'b0;
    tx_done  = 1'b0;
    check("viol_sticky", {29'd0, o_violation, o_scl, o_rx_done}, 32'b110);
    check("viol_data", o_data, 8'h07);
    check("viol_cnt", o_bit_cnt, 3);
    rstn = 1'b0;
    @(negedge clk);
    check("viol_reset", {29'd0, o_violation, o_scl, o_rx_done}, 32'b011);
    check("viol_reset_data", o_data, 0);
    rstn = 1'b1;
    ext_sda = 1'b1;
    @(negedge clk);

    // SCL held low by the far side after release.
    ext_scl = 1'b0;
    do_start(1'b0);
    wait_scl(1'b1, "to_rel");
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_timeout === 1'b1) pulses++;
    end
`ifdef I2C_PASSTHRU_WORDRX_STRETCH_TO_EN
    check("to_pulses", pulses, 1);
    check("to_viol", {31'd0, o_violation}, 32'd1);
`else
    check("to_pulses", pulses, 0);
    check("to_waiting", {29'd0, o_violation, o_scl, o_rx_done}, 32'b010);
`endif
    do_reset();

    // Randomized transactions against an arithmetic model.
    for (int r = 0; r < 12; r++) begin
      bit         slv;
      int         nb, term;
      logic [7:0] val, exp_d;
      slv  = ($urandom_range(0, 2) == 0);
      val  = 8'($urandom);
      nb   = slv ? NUM_BITS : $urandom_range(0, NUM_BITS);
      term = (nb == NUM_BITS) ? 0 : $urandom_range(1, 2);
      exp_d = 8'(int'(val) % (1 << nb));
      if (slv) slave_txn(val, -1, 1'b1);
      else     master_txn(nb, val, term, 2, 1'b1);
      check_result("rand", exp_d, nb, term);
      finish_txn("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
